// File: rtl/aes_img_pkg.sv
// Shared definitions for the image-encryption path (pixel packer and CBC encryptor).
package aes_img_pkg;

  localparam int AES_BLK_W = 128;
  localparam int BLK_BYTES = 16;

  // A full PKCS#7 pad block: sixteen bytes of value 16.
  localparam logic [AES_BLK_W-1:0] PKCS7_FULL_PAD = {BLK_BYTES{8'h10}};

  typedef enum logic [1:0] {
    COLLECT  = 2'd0,
    EMIT     = 2'd1,
    PAD_EMIT = 2'd2
  } blk_state_t;

endpackage

// File: rtl/aes_pad_fill.sv
// Fills the unused tail of a partial block: PKCS#7 value bytes when PKCS7_PAD_EN
// is defined, zero bytes otherwise. byte_cnt is the number of valid leading bytes (1..16).
module aes_pad_fill
  import aes_img_pkg::*;
(
  input  logic [AES_BLK_W-1:0] partial,
  input  logic [4:0]           byte_cnt,
  output logic [AES_BLK_W-1:0] filled
);

  logic [7:0] pad_val;

`ifdef PKCS7_PAD_EN
  logic [4:0] pad_len;
  assign pad_len = 5'd16 - byte_cnt;
  assign pad_val = {3'b000, pad_len};
`else
  assign pad_val = 8'h00;
`endif

  generate
    for (genvar gi = 0; gi < BLK_BYTES; gi++) begin : g_lane
      localparam logic [4:0] LANE = 5'(gi);
      assign filled[AES_BLK_W-1-8*gi -: 8] =
        (LANE < byte_cnt) ? partial[AES_BLK_W-1-8*gi -: 8] : pad_val;
    end
  endgenerate

endmodule

// File: rtl/aes_pixel_packer.sv
// Packs a pixel byte stream into 128-bit MSB-first plaintext blocks for the CBC encryptor.
// Optional PKCS#7 padding of the final block is enabled by defining PKCS7_PAD_EN.
module aes_pixel_packer
  import aes_img_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           in_byte,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [AES_BLK_W-1:0] out_block,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic [CNT_W-1:0]     blk_count
);

`ifdef PKCS7_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  blk_state_t           state_reg, state_next;
  logic [3:0]           idx_reg;
  logic [AES_BLK_W-1:0] buf_reg;
  logic [AES_BLK_W-1:0] merged;
  logic [AES_BLK_W-1:0] fill_out;
  logic [AES_BLK_W-1:0] out_block_reg;
  logic                 out_valid_reg;
  logic                 out_last_reg;
  logic                 pad_pending_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic                 in_xfer;
  logic                 out_xfer;
  logic                 close_blk;
  logic                 full_last;

  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid_reg && out_ready;
  assign close_blk = in_xfer && ((idx_reg == 4'hF) || in_last);
  assign full_last = in_last && (idx_reg == 4'hF);

  // The incoming byte is merged combinationally so a closing byte lands in this cycle's block.
  generate
    for (genvar gi = 0; gi < BLK_BYTES; gi++) begin : g_merge
      assign merged[AES_BLK_W-1-8*gi -: 8] =
        (idx_reg == 4'(gi)) ? in_byte : buf_reg[AES_BLK_W-1-8*gi -: 8];
    end
  endgenerate

  aes_pad_fill u_pad_fill (
    .partial  (merged),
    .byte_cnt ({1'b0, idx_reg} + 5'd1),
    .filled   (fill_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= COLLECT;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    case (state_reg)
      COLLECT: begin
        in_ready = 1'b1;
        if (in_valid && ((idx_reg == 4'hF) || in_last)) begin
          state_next = EMIT;
        end
      end
      EMIT: begin
        if (out_valid_reg && out_ready) begin
          state_next = pad_pending_reg ? PAD_EMIT : COLLECT;
        end
      end
      PAD_EMIT: begin
        if (out_valid_reg && out_ready) begin
          state_next = COLLECT;
        end
      end
      default: state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg         <= 4'd0;
      buf_reg         <= '0;
      out_block_reg   <= '0;
      out_valid_reg   <= 1'b0;
      out_last_reg    <= 1'b0;
      pad_pending_reg <= 1'b0;
      cnt_reg         <= '0;
    end else begin
      if (in_xfer) begin
        buf_reg <= merged;
        idx_reg <= idx_reg + 4'd1;
        if (close_blk) begin
          out_block_reg   <= fill_out;
          out_valid_reg   <= 1'b1;
          // A full closing block hands out_last over to the trailing pad block.
          out_last_reg    <= in_last && !(full_last && PAD_EN);
          pad_pending_reg <= full_last && PAD_EN;
        end
      end
      if (out_xfer) begin
        cnt_reg <= cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
        if (pad_pending_reg) begin
          out_block_reg   <= PKCS7_FULL_PAD;
          out_last_reg    <= 1'b1;
          pad_pending_reg <= 1'b0;
        end else begin
          out_valid_reg <= 1'b0;
          out_last_reg  <= 1'b0;
          idx_reg       <= 4'd0;
        end
      end
    end
  end

  assign out_block = out_block_reg;
  assign out_valid = out_valid_reg;
  assign out_last  = out_last_reg;
  assign blk_count = cnt_reg;

endmodule

// File: tb/tb_aes_pixel_packer.sv
// Directed bench for aes_pixel_packer; expectations follow PKCS7_PAD_EN when defined.
module tb_aes_pixel_packer;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   in_byte;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [127:0] out_block;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic [15:0]  blk_count;

  logic         in_ready2;
  logic [127:0] out_block2;
  logic         out_valid2;
  logic         out_last2;
  logic [1:0]   blk_count2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  aes_pixel_packer #(.CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_block(out_block), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .blk_count(blk_count)
  );

  aes_pixel_packer #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready2), .out_block(out_block2), .out_valid(out_valid2),
    .out_ready(out_ready), .out_last(out_last2), .blk_count(blk_count2)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Sends the first n bytes of data (MSB first); returns on the negedge after the last transfer.
  task automatic send_bytes(input logic [127:0] data, input int n, input bit last);
    int t;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_byte  = data[127-8*i -: 8];
      in_last  = last && (i == n - 1);
      t = 0;
      while (!in_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) begin
        checks++; errors++;
        $display("FAIL send_timeout: in_ready=%0b required 1 for byte %0d", in_ready, i);
      end
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_byte = 8'h00; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %0b expected 0", out_last); end
    checks++; if (out_block !== 128'h0) begin errors++; $display("FAIL reset_out_block: got %h expected 0", out_block); end
    checks++; if (blk_count !== 16'd0) begin errors++; $display("FAIL reset_blk_count: got %0d expected 0", blk_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
    $display("test_reset done");
  endtask

  task automatic test_stream();
    logic [127:0] exp_blk;
    exp_blk = 128'h00112233445566778899aabbccddeeff;
    do_reset();
    out_ready = 1'b1;
    send_bytes(exp_blk, 16, 1'b0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid: got %0b expected 1", out_valid); end
    checks++; if (out_block !== exp_blk) begin errors++; $display("FAIL stream_block: got %h expected %h", out_block, exp_blk); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL stream_last: got %0b expected 0", out_last); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_valid_drop: got %0b expected 0", out_valid); end
    checks++; if (blk_count !== 16'd1) begin errors++; $display("FAIL stream_count: got %0d expected 1", blk_count); end
    $display("test_stream block=%h", exp_blk);
  endtask

  task automatic test_partial();
    logic [127:0] exp_blk;
    logic [127:0] next_blk;
`ifdef PKCS7_PAD_EN
    exp_blk = 128'haabbcc0d_0d0d0d0d_0d0d0d0d_0d0d0d0d;
`else
    exp_blk = 128'haabbcc00_00000000_00000000_00000000;
`endif
    next_blk = 128'h0102030405060708090a0b0c0d0e0f10;
    do_reset();
    out_ready = 1'b1;
    send_bytes(128'haabbcc00_00000000_00000000_00000000, 3, 1'b1);
    checks++; if (out_block !== exp_blk) begin errors++; $display("FAIL partial_block: got %h expected %h", out_block, exp_blk); end
    checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL partial_last: got %0b expected 1", out_last); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL partial_valid_drop: got %0b expected 0", out_valid); end
    checks++; if (blk_count !== 16'd1) begin errors++; $display("FAIL partial_count: got %0d expected 1", blk_count); end
    send_bytes(next_blk, 16, 1'b0);
    checks++; if (out_block !== next_blk) begin errors++; $display("FAIL partial_next_block: got %h expected %h", out_block, next_blk); end
    $display("test_partial block=%h", exp_blk);
  endtask

  task automatic test_full_last();
    logic [127:0] data;
    data = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f;
    do_reset();
    out_ready = 1'b1;
    send_bytes(data, 16, 1'b1);
    checks++; if (out_block !== data) begin errors++; $display("FAIL full_last_block: got %h expected %h", out_block, data); end
`ifdef PKCS7_PAD_EN
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL full_last_data_last: got %0b expected 0", out_last); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL full_last_pad_valid: got %0b expected 1", out_valid); end
    checks++; if (out_block !== 128'h10101010_10101010_10101010_10101010) begin errors++; $display("FAIL full_last_pad_block: got %h expected 1010..10", out_block); end
    checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL full_last_pad_last: got %0b expected 1", out_last); end
    @(negedge clk);
    checks++; if (blk_count !== 16'd2) begin errors++; $display("FAIL full_last_count: got %0d expected 2", blk_count); end
`else
    checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL full_last_last: got %0b expected 1", out_last); end
    @(negedge clk);
    checks++; if (blk_count !== 16'd1) begin errors++; $display("FAIL full_last_count: got %0d expected 1", blk_count); end
`endif
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_last_valid_drop: got %0b expected 0", out_valid); end
    $display("test_full_last count=%0d", blk_count);
  endtask

  task automatic test_stall();
    logic [127:0] blk_a;
    logic [127:0] blk_b;
    blk_a = 128'h112233445566778899aabbccddeeff00;
    blk_b = 128'hcafef00d_12345678_9abcdef0_0badbeef;
    do_reset();
    out_ready = 1'b0;
    send_bytes(blk_a, 16, 1'b0);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_byte  = 8'h5a;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %0b expected 1", c, out_valid); end
      checks++; if (out_block !== blk_a) begin errors++; $display("FAIL stall_block[%0d]: got %h expected %h", c, out_block, blk_a); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d]: got %0b expected 0", c, in_ready); end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_release_valid: got %0b expected 0", out_valid); end
    checks++; if (blk_count !== 16'd1) begin errors++; $display("FAIL stall_release_count: got %0d expected 1", blk_count); end
    send_bytes(blk_b, 16, 1'b0);
    checks++; if (out_block !== blk_b) begin errors++; $display("FAIL stall_next_block: got %h expected %h", out_block, blk_b); end
    $display("test_stall held=%h next=%h", blk_a, blk_b);
  endtask

  task automatic test_reset_mid();
    logic [127:0] blk_c;
    blk_c = 128'h202122232425262728292a2b2c2d2e2f;
    do_reset();
    out_ready = 1'b1;
    send_bytes(128'hdeadbeef_01020304_05060708_090a0b0c, 7, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send_bytes(blk_c, 16, 1'b0);
    checks++; if (out_block !== blk_c) begin errors++; $display("FAIL reset_mid_block: got %h expected %h", out_block, blk_c); end
    @(negedge clk);
    checks++; if (blk_count !== 16'd1) begin errors++; $display("FAIL reset_mid_count: got %0d expected 1", blk_count); end
    out_ready = 1'b0;
    send_bytes(blk_c, 16, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_pending_valid: got %0b expected 0", out_valid); end
    @(negedge clk);
    checks++; if (blk_count !== 16'd0) begin errors++; $display("FAIL reset_pending_count: got %0d expected 0", blk_count); end
    $display("test_reset_mid count=%0d", blk_count);
  endtask

  task automatic test_count_wrap();
    int exp_wrap [5];
    exp_wrap = '{1, 2, 3, 0, 1};
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      send_bytes({16{8'(k + 1)}}, 16, 1'b0);
      @(negedge clk);
      checks++; if (blk_count2 !== 2'(exp_wrap[k])) begin errors++; $display("FAIL wrap_count2[%0d]: got %0d expected %0d", k, blk_count2, exp_wrap[k]); end
      checks++; if (blk_count !== 16'(k + 1)) begin errors++; $display("FAIL wrap_count16[%0d]: got %0d expected %0d", k, blk_count, k + 1); end
      $display("test_count_wrap block %0d count2=%0d", k, blk_count2);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_partial();
    test_full_last();
    test_stall();
    test_reset_mid();
    test_count_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_pixel_packer.md
AES_PIXEL_PACKER -- requirements
Module: aes_pixel_packer

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, meaning the width of the emitted-block counter.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-003 The block SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-004 The block SHALL have port in_byte, input, 8, a pixel byte.
REQ-005 The block SHALL have port in_valid, input, 1, meaning in_byte is valid.
REQ-006 The block SHALL have port in_last, input, 1, meaning the byte is the final byte of the image; qualified by in_valid.
REQ-007 The block SHALL have port in_ready, output, 1, meaning the packer accepts a byte this cycle.
REQ-008 The block SHALL have port out_block, output, 128, the plaintext block for the CBC encryptor.
REQ-009 The block SHALL have port out_valid, output, 1, meaning out_block is valid.
REQ-010 The block SHALL have port out_ready, input, 1, the downstream encryptor's accept signal.
REQ-011 The block SHALL have port out_last, output, 1, meaning the block is the final block of the image.
REQ-012 The block SHALL have port blk_count, output, CNT_W, the count of blocks handed off since reset.

Function
REQ-013 An input transfer SHALL occur when in_valid && in_ready; an output transfer SHALL occur when out_valid && out_ready.
REQ-014 The first accepted byte of a block SHALL land in out_block[127:120] and the 16th in [7:0] (MSB-first, matching hex plaintext order).
REQ-015 The FSM SHALL have states COLLECT, EMIT and PAD_EMIT.
REQ-016 in_ready SHALL be 1 only in COLLECT, combinationally.
REQ-017 A 4-bit byte index SHALL increment per input transfer and wrap 15->0.
REQ-018 On the transfer of byte 16, or of any byte with in_last=1, the next state SHALL be EMIT with out_valid=1 on the following cycle (1-cycle latency).
REQ-019 out_block, out_valid and out_last SHALL be registered and held stable until the output transfer (no drop, no change while stalled).
REQ-020 out_last SHALL be 1 for the block that closes the image, unless a PAD_EMIT block follows (REQ-028), in which case only that pad block carries out_last.
REQ-021 On an output transfer in EMIT, the FSM SHALL go to PAD_EMIT if a pad block is pending, else to COLLECT with the index cleared.
REQ-022 On an output transfer in PAD_EMIT, the FSM SHALL go to COLLECT.
REQ-023 blk_count SHALL increment by 1 per output transfer and wrap modulo 2^CNT_W.
REQ-024 Bytes are never accepted in EMIT/PAD_EMIT, so the same-cycle input/output transfer case cannot occur; in_valid held high there SHALL be ignored without loss.
REQ-025 in_last on byte 16 SHALL close that block as full (no partial handling).

Reset
REQ-026 With rst=1 at a clock edge: state=COLLECT, index=0, out_valid=0, out_last=0, out_block=0, blk_count=0; in_ready=1 from the first cycle after reset.
REQ-027 Reset asserted mid-block or while out_valid=1 SHALL discard the partial or pending block with no output transfer.

Configuration
REQ-028 With PKCS7_PAD_EN defined:
- A final partial block of n bytes SHALL fill its remaining 16-n bytes with value 16-n.
- A final full block SHALL be followed by PAD_EMIT emitting 128'h10101010_10101010_10101010_10101010 with out_last=1.
REQ-029 Without PKCS7_PAD_EN:
- Remaining bytes SHALL be zero.
- PAD_EMIT SHALL never be entered; the closing block carries out_last.

Structure
REQ-030 Package aes_img_pkg SHALL hold AES_BLK_W=128, BLK_BYTES=16 and the FSM state enum; the sibling CBC encryptor shares it.
REQ-031 The pad-fill logic SHALL live in one sub-module, aes_pad_fill (inputs: partial block, byte count; output: filled block), used by no other state.

Verification
REQ-032 Stream bytes 00,11,..,ff with out_ready=1 -> one block 128'h00112233445566778899aabbccddeeff, 1 cycle after byte 16; blk_count=1.
REQ-033 Send 3 bytes aa,bb,cc with in_last on cc:
- PKCS7_PAD_EN defined -> aabbcc0d0d..0d (13 bytes of 0d), out_last=1.
- PKCS7_PAD_EN undefined -> aabbcc00..00, out_last=1.
REQ-034 Send 16 bytes with in_last on byte 16, PKCS7_PAD_EN defined -> data block with out_last=0, then the 1010..10 block with out_last=1; blk_count=2.
REQ-035 Hold out_ready=0 for 5 cycles after out_valid -> out_block stable, in_ready=0, no byte lost; transfer on the cycle out_ready rises.
REQ-036 Assert rst after byte 7, then stream 16 new bytes -> first emitted block contains only the new bytes; blk_count=1.
REQ-037 With CNT_W=2, send 5 blocks -> blk_count sequence 1,2,3,0,1.
